// File: rtl/i2c_reg_master_pkg.sv
// rtl/i2c_reg_master_pkg.sv - shared state, phase and register-map definitions for i2c_reg_master
package i2c_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TXBYTE,
    ST_TXACK,
    ST_RSTART,
    ST_RXBYTE,
    ST_RXNACK,
    ST_STOP
  } state_t;

  // Which byte of the transaction is on the wire
  typedef enum logic [1:0] {
    PH_ADDR_W,
    PH_REG,
    PH_DATA,
    PH_ADDR_R
  } phase_t;

  localparam logic [1:0] REG_DEV  = 2'd0;
  localparam logic [1:0] REG_REG  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_GO       = 0;
  localparam int CTRL_RW       = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_CLR_DONE = 3;

  // STAT read bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ACK_ERR = 2;
  localparam int STAT_IRQ_EN  = 3;

  // SCL is held low in the first and last quarter of every bit
  function automatic logic quarter_scl_low(input logic [1:0] q);
    return (q == 2'd0) || (q == 2'd3);
  endfunction

endpackage

// File: rtl/i2c_bit_tick.sv
// rtl/i2c_bit_tick.sv - quarter-SCL tick generator; I2C_CLOCK_STRETCH_EN adds slave clock-stretch hold
module i2c_bit_tick
  import i2c_reg_master_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic scl_rel,
  input  logic scl_in,
  output logic tick
);

  localparam logic [9:0] CNT_MAX = 10'(CLK_DIV - 1);

  logic [9:0] cnt;
  logic       hold;

`ifdef I2C_CLOCK_STRETCH_EN
  // SCL has been released by the master but a slave is still holding it low
  assign hold = scl_rel && !scl_in;
`else
  logic unused_stretch;
  assign hold           = 1'b0;
  assign unused_stretch = scl_rel ^ scl_in;
`endif

  assign tick = run && !hold && (cnt == CNT_MAX);

  // Free-running divider while a transfer is active, parked at zero otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 10'd0;
    end else if (!run) begin
      cnt <= 10'd0;
    end else if (!hold) begin
      cnt <= (cnt == CNT_MAX) ? 10'd0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// rtl/i2c_reg_master.sv - Avalon-MM I2C register master (clock stretching via I2C_CLOCK_STRETCH_EN)
module i2c_reg_master
  import i2c_reg_master_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        irq
);

  logic [6:0] dev_r;
  logic [7:0] reg_r;
  logic [7:0] data_tx;
  logic [7:0] data_rx;
  logic [7:0] sr;
  logic       irq_en;
  logic       done;
  logic       ack_err;
  logic       rw_r;
  state_t     state;
  phase_t     phase;
  logic [1:0] q;
  logic [2:0] bitcnt;

  logic tick;
  logic busy;
  logic wr_en;
  logic go_accept;
  logic clr_done;
  logic scl_rel;
  logic scl_low_c;
  logic sda_low_c;
  logic unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign busy      = (state != ST_IDLE);
  assign go_accept = wr_en && (address == REG_CTRL) && writedata[CTRL_GO] && !busy;
  assign clr_done  = wr_en && (address == REG_CTRL) && writedata[CTRL_CLR_DONE];
  assign scl_rel   = busy && (q == 2'd1);
  assign irq       = done && irq_en;
  assign unused_wd = ^writedata[31:8];

  i2c_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (busy),
    .scl_rel (scl_rel),
    .scl_in  (scl_in),
    .tick    (tick)
  );

  // Software-visible configuration; address/data fields are frozen during a transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dev_r   <= 7'd0;
      reg_r   <= 8'd0;
      data_tx <= 8'd0;
      irq_en  <= 1'b0;
    end else if (wr_en) begin
      case (address)
        REG_DEV:  if (!busy) dev_r <= writedata[6:0];
        REG_REG:  if (!busy) reg_r <= writedata[7:0];
        REG_DATA: if (!busy) data_tx <= writedata[7:0];
        REG_CTRL: irq_en <= writedata[CTRL_IRQ_EN];
        default:  ;
      endcase
    end
  end

  // Pad drive pattern for the current state and quarter
  always_comb begin
    scl_low_c = 1'b0;
    sda_low_c = 1'b0;
    case (state)
      ST_IDLE: begin
        scl_low_c = 1'b0;
        sda_low_c = 1'b0;
      end
      ST_START: begin
        scl_low_c = (q == 2'd3);
        sda_low_c = (q >= 2'd2);
      end
      ST_RSTART: begin
        scl_low_c = quarter_scl_low(q);
        sda_low_c = (q >= 2'd2);
      end
      ST_TXBYTE: begin
        scl_low_c = quarter_scl_low(q);
        sda_low_c = !sr[7];
      end
      ST_TXACK, ST_RXBYTE, ST_RXNACK: begin
        scl_low_c = quarter_scl_low(q);
        sda_low_c = 1'b0;
      end
      ST_STOP: begin
        scl_low_c = (q == 2'd0);
        sda_low_c = (q <= 2'd1);
      end
      default: begin
        scl_low_c = 1'b0;
        sda_low_c = 1'b0;
      end
    endcase
  end

  // Transfer sequencer: quarter/bit tracking, byte phases, status flags and registered pad drives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      phase   <= PH_ADDR_W;
      q       <= 2'd0;
      bitcnt  <= 3'd0;
      sr      <= 8'd0;
      rw_r    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      data_rx <= 8'd0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      scl_oe <= scl_low_c;
      sda_oe <= sda_low_c;
      if (clr_done) done <= 1'b0;
      if (go_accept) begin
        state   <= ST_START;
        q       <= 2'd0;
        done    <= 1'b0;
        ack_err <= 1'b0;
        rw_r    <= writedata[CTRL_RW];
      end else if (busy && tick) begin
        q <= q + 2'd1;
        if (q == 2'd2) begin
          if (state == ST_TXACK && sda_in) ack_err <= 1'b1;
          if (state == ST_RXBYTE) sr <= {sr[6:0], sda_in};
        end
        if (q == 2'd3) begin
          case (state)
            ST_START: begin
              state  <= ST_TXBYTE;
              phase  <= PH_ADDR_W;
              sr     <= {dev_r, 1'b0};
              bitcnt <= 3'd7;
            end
            ST_TXBYTE: begin
              if (bitcnt == 3'd0) begin
                state <= ST_TXACK;
              end else begin
                bitcnt <= bitcnt - 3'd1;
                sr     <= {sr[6:0], 1'b0};
              end
            end
            ST_TXACK: begin
              if (ack_err) begin
                state <= ST_STOP;
              end else begin
                case (phase)
                  PH_ADDR_W: begin
                    state  <= ST_TXBYTE;
                    phase  <= PH_REG;
                    sr     <= reg_r;
                    bitcnt <= 3'd7;
                  end
                  PH_REG: begin
                    if (rw_r) begin
                      state <= ST_RSTART;
                    end else begin
                      state  <= ST_TXBYTE;
                      phase  <= PH_DATA;
                      sr     <= data_tx;
                      bitcnt <= 3'd7;
                    end
                  end
                  PH_DATA:   state <= ST_STOP;
                  PH_ADDR_R: begin
                    state  <= ST_RXBYTE;
                    bitcnt <= 3'd7;
                  end
                  default:   state <= ST_STOP;
                endcase
              end
            end
            ST_RSTART: begin
              state  <= ST_TXBYTE;
              phase  <= PH_ADDR_R;
              sr     <= {dev_r, 1'b1};
              bitcnt <= 3'd7;
            end
            ST_RXBYTE: begin
              if (bitcnt == 3'd0) state <= ST_RXNACK;
              else bitcnt <= bitcnt - 3'd1;
            end
            ST_RXNACK: state <= ST_STOP;
            ST_STOP: begin
              state <= ST_IDLE;
              done  <= 1'b1;
              if (rw_r && !ack_err) data_rx <= sr;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Zero-extended register read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      REG_DEV:  readdata[6:0] = dev_r;
      REG_REG:  readdata[7:0] = reg_r;
      REG_DATA: readdata[7:0] = data_rx;
      REG_CTRL: begin
        readdata[STAT_BUSY]    = busy;
        readdata[STAT_DONE]    = done;
        readdata[STAT_ACK_ERR] = ack_err;
        readdata[STAT_IRQ_EN]  = irq_en;
      end
      default:  readdata = 32'd0;
    endcase
  end

endmodule
